// File: rtl/axi4_wr_engine_pkg.sv
// Shared types for the AXI4-lite write engine: FSM state and B codes.
// No ports; imported by the interface and the engine.
package axi4_wr_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_wr_engine_if.sv
// Bundle of AW/W/B FIFO taps and register-bus signals for the write engine.
// master: engine side (pops AW/W, pushes B, drives reg bus); slave: environment.
interface axi4_lite_wr_engine_if #(
  parameter int A_W = 32,
  parameter int D_W = 32
);
  import axi4_wr_engine_pkg::*;

  logic             aw_rd_empty;
  logic             aw_rd_en;
  logic [A_W-1:0]   aw_addr;

  logic             w_rd_empty;
  logic             w_rd_en;
  logic [D_W-1:0]   w_data;
  logic [D_W/8-1:0] w_strb;

  logic             b_wr_full;
  logic             b_wr_en;
  logic [1:0]       b_resp;

  logic             reg_req;
  logic [A_W-1:0]   reg_addr;
  logic [D_W-1:0]   reg_wdata;
  logic [D_W/8-1:0] reg_strb;
  logic             reg_ack;
  logic             reg_err;

  modport master (
    input  aw_rd_empty, aw_addr,
    input  w_rd_empty, w_data, w_strb,
    input  b_wr_full,
    input  reg_ack, reg_err,
    output aw_rd_en, w_rd_en,
    output b_wr_en, b_resp,
    output reg_req, reg_addr,
    output reg_wdata, reg_strb
  );

  modport slave (
    output aw_rd_empty, aw_addr,
    output w_rd_empty, w_data, w_strb,
    output b_wr_full,
    output reg_ack, reg_err,
    input  aw_rd_en, w_rd_en,
    input  b_wr_en, b_resp,
    input  reg_req, reg_addr,
    input  reg_wdata, reg_strb
  );

endinterface

// File: rtl/axi4_lite_wr_engine.sv
// AXI4-lite write engine: pops paired AW/W FIFO words, issues one register
// write, pushes the B response. Ports: aclk, aresetn (async, active-low),
// bus (master modport: FIFO taps + reg bus), busy (not IDLE).
// Optional reg_ack timeout enabled by defining AXI4_WR_ENGINE_TIMEOUT_EN.
module axi4_lite_wr_engine
  import axi4_wr_engine_pkg::*;
#(
  parameter int A_W            = 32,
  parameter int D_W            = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  axi4_lite_wr_engine_if.master         bus,
  output logic                          busy
);

  state_t           state;
  logic             pop;
  logic             req_q;
  logic [A_W-1:0]   addr_q;
  logic [D_W-1:0]   data_q;
  logic [D_W/8-1:0] strb_q;
  logic [1:0]       resp_q;

`ifdef AXI4_WR_ENGINE_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Pop only when both heads are present so AW and W stay paired.
  assign pop = (state == IDLE) &
               ~bus.aw_rd_empty &
               ~bus.w_rd_empty;

  assign bus.aw_rd_en  = pop;
  assign bus.w_rd_en   = pop;
  assign bus.b_wr_en   = (state == RESP) & ~bus.b_wr_full;
  assign bus.b_resp    = resp_q;
  assign bus.reg_req   = req_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = data_q;
  assign bus.reg_strb  = strb_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
      resp_q <= RESP_OKAY;
`ifdef AXI4_WR_ENGINE_TIMEOUT_EN
      cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            addr_q <= bus.aw_addr;
            data_q <= bus.w_data;
            strb_q <= bus.w_strb;
            req_q  <= 1'b1;
            state  <= REQ;
`ifdef AXI4_WR_ENGINE_TIMEOUT_EN
            cnt    <= '0;
`endif
          end
        end
        REQ: begin
          // An ack in the expiry cycle wins over the timeout.
          if (bus.reg_ack) begin
            req_q  <= 1'b0;
            resp_q <= bus.reg_err ? RESP_SLVERR : RESP_OKAY;
            state  <= RESP;
`ifdef AXI4_WR_ENGINE_TIMEOUT_EN
          end else if (cnt == LAST) begin
            req_q  <= 1'b0;
            resp_q <= RESP_SLVERR;
            state  <= RESP;
          end else begin
            cnt    <= cnt + CW'(1);
`endif
          end
        end
        RESP: begin
          if (!bus.b_wr_full) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi4_lite_wr_engine.md
AXI4_LITE_WR_ENGINE -- requirements
Module: axi4_lite_wr_engine

Interface
REQ-001 Parameter A_W, default 32, address width.
REQ-002 Parameter D_W, default 32, data width; legal values are multiples of 8.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, reg_ack wait limit (used only under REQ-023).
REQ-004 aclk  in  1  single clock; all logic on rising edge.
REQ-005 aresetn  in  1  asynchronous, active-low reset.
REQ-006 aw_rd_empty  in  1  AW FIFO empty; aw_rd_en  out  1  AW FIFO pop.
REQ-007 aw_addr  in  A_W  AW FIFO head word; FIFO is first-word-fall-through.
REQ-008 w_rd_empty  in  1  W FIFO empty; w_rd_en  out  1  W FIFO pop.
REQ-009 w_data  in  D_W, w_strb  in  D_W/8  W FIFO head word.
REQ-010 b_wr_full  in  1  B FIFO full; b_wr_en  out  1  B FIFO push; b_resp  out  2  pushed response.
REQ-011 reg_req  out  1; reg_addr  out  A_W; reg_wdata  out  D_W; reg_strb  out  D_W/8  register-bus write request.
REQ-012 reg_ack  in  1, reg_err  in  1  register-bus completion and error, valid when reg_ack=1.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, REQ, RESP.
REQ-015 IDLE: when aw_rd_empty=0 and w_rd_empty=0, aw_rd_en and w_rd_en SHALL both assert combinationally in the same cycle; the FSM moves to REQ.
REQ-016 On that pop edge, aw_addr, w_data and w_strb SHALL be registered into reg_addr, reg_wdata and reg_strb; reg_req SHALL be 1 from the next cycle.
REQ-017 If only one FIFO is non-empty, neither FIFO SHALL be popped.
REQ-018 REQ: reg_req, reg_addr, reg_wdata and reg_strb SHALL stay stable until the cycle reg_ack=1. On that edge, reg_req SHALL drop, b_resp SHALL load 2'b10 if reg_err=1 and 2'b00 otherwise, and the FSM moves to RESP.
REQ-019 RESP: b_wr_en SHALL equal ~b_wr_full. On a push the FSM returns to IDLE. While b_wr_full=1 it SHALL hold RESP with b_resp stable.
REQ-020 Minimum occupancy is 3 cycles per write (pop, ack, push). No overlap between transactions.
REQ-021 aw_rd_en, w_rd_en and b_wr_en SHALL never assert outside IDLE, IDLE and RESP respectively.

Reset
REQ-022 On aresetn=0 (any state, mid-transaction included): FSM goes to IDLE; reg_req, reg_addr, reg_wdata, reg_strb, b_resp and the timeout counter go to 0; busy=0; the in-flight write is discarded without a B response.

Configuration
REQ-023 With AXI4_WR_ENGINE_TIMEOUT_EN defined:
- a counter SHALL clear on entry to REQ and increment each REQ cycle;
- after TIMEOUT_CYCLES REQ cycles without reg_ack, reg_req SHALL drop, b_resp SHALL load 2'b10 and the FSM goes to RESP;
- if reg_ack arrives in the expiry cycle, the ack wins and b_resp reflects reg_err.
REQ-024 Without the macro, no counter exists, REQ waits indefinitely and TIMEOUT_CYCLES is ignored.

Structure
REQ-025 Package axi4_wr_engine_pkg SHALL hold the state enum and the response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
REQ-026 The block SHALL be a single module with no sub-modules. FSM, capture registers and the optional counter are inline.

Verification
REQ-027 AW addr 0x10 and W data 0xDEADBEEF, strb 0xF, pushed together; reg_ack one cycle later with reg_err=0 -> one reg_req with those values; b_resp=00 pushed 3 cycles after the pop.
REQ-028 AW present, W empty for 5 cycles -> no pop and reg_req=0; W arrives -> both FIFOs popped in the same cycle.
REQ-029 reg_ack with reg_err=1 -> b_resp=2'b10 pushed.
REQ-030 b_wr_full=1 for 4 cycles in RESP -> b_wr_en=0 and busy=1 during those cycles; push in the cycle full drops; no new pop meanwhile.
REQ-031 Macro on, TIMEOUT_CYCLES=8, reg_ack never asserted -> reg_req drops after 8 cycles; b_resp=2'b10 pushed.
REQ-032 aresetn pulsed low during REQ -> reg_req=0 immediately; no B push; the next write completes normally.
